// File: rtl/spi_slave_cmd_decoder.sv
// SPI byte stream to APB plug commands, write words and read bytes.
// Define SPI_SLAVE_CMD_STATUS_EN to enable the READ_STATUS (8'h05) command.
module spi_slave_cmd_decoder #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned DUMMY_BYTES    = 1,
  parameter logic [7:0]  UNDERRUN_BYTE  = 8'hFF
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      cs,
  input  logic [7:0]                byte_in,
  input  logic                      byte_in_valid,
  output logic [7:0]                byte_out,
  output logic                      byte_out_valid,
  input  logic                      byte_out_ready,
  output logic [APB_ADDR_WIDTH-1:0] rxtx_addr,
  output logic                      rxtx_addr_valid,
  output logic                      start_tx,
  output logic [APB_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic [APB_DATA_WIDTH-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [15:0]               wrap_length,
  output logic                      err_overrun,
  output logic                      err_underrun
);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_WDATA,
    S_RDATA,
    S_WRAP,
    S_IGNORE
  } state_t;

  localparam logic [7:0] LP_WRITE = 8'h02;
  localparam logic [7:0] LP_READ  = 8'h0B;
  localparam logic [7:0] LP_WRAP  = 8'h11;
  localparam logic [7:0] LP_STAT  = 8'h05;
  localparam logic [1:0] LP_DLAST = 2'(DUMMY_BYTES - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]                r_cnt;
  logic [23:0]               r_shift;
  logic                      r_is_read;
  logic [APB_DATA_WIDTH-1:0] r_buf;
  logic [2:0]                r_occ;
  logic                      r_addr_vld;
  logic                      r_start;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_rx_data;
  logic                      r_rx_valid;
  logic [15:0]               r_wrap;
  logic                      r_err_o;
  logic                      r_err_u;

  logic        w_byte;
  logic [31:0] w_word;
  logic        w_cmd_rw;
  logic        w_cmd_wrap;
  logic        w_cmd_stat;
  logic        w_addr_done;
  logic        w_word_done;
  logic        w_wrap_done;
  logic        w_stat_load;
  logic        w_capture;
  logic        w_pop;
  logic        w_underrun;

  assign w_byte      = byte_in_valid & ~cs;
  assign w_word      = {r_shift, byte_in};
  assign w_cmd_rw    = (byte_in == LP_WRITE) | (byte_in == LP_READ);
  assign w_cmd_wrap  = (byte_in == LP_WRAP);
  assign w_addr_done = w_byte & (r_state == S_ADDR) & (r_cnt == 2'd3);
  assign w_word_done = w_byte & (r_state == S_WDATA) & (r_cnt == 2'd3);
  assign w_wrap_done = w_byte & (r_state == S_WRAP) & (r_cnt == 2'd1);

`ifdef SPI_SLAVE_CMD_STATUS_EN
  assign w_cmd_stat  = (byte_in == LP_STAT);
  assign w_stat_load = w_byte & (r_state == S_CMD) & w_cmd_stat;
`else
  assign w_cmd_stat  = 1'b0;
  assign w_stat_load = 1'b0;
`endif

  assign tx_ready   = (r_state == S_RDATA) & (r_occ == 3'd0) & ~cs;
  assign w_capture  = tx_valid & tx_ready;
  assign w_pop      = byte_out_ready & (r_occ != 3'd0);
  assign w_underrun = byte_out_ready & (r_occ == 3'd0);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cs) begin
      w_state_nxt = S_CMD;
    end else if (byte_in_valid) begin
      case (r_state)
        S_CMD: begin
          unique case (1'b1)
            w_cmd_rw:   w_state_nxt = S_ADDR;
            w_cmd_wrap: w_state_nxt = S_WRAP;
            w_cmd_stat: w_state_nxt = S_IGNORE;
            default:    w_state_nxt = S_IGNORE;
          endcase
        end
        S_ADDR: begin
          if (r_cnt == 2'd3) begin
            if (!r_is_read)
              w_state_nxt = S_WDATA;
            else if (DUMMY_BYTES == 0)
              w_state_nxt = S_RDATA;
            else
              w_state_nxt = S_DUMMY;
          end
        end
        S_DUMMY: begin
          if (r_cnt == LP_DLAST)
            w_state_nxt = S_RDATA;
        end
        S_WRAP: begin
          if (r_cnt == 2'd1)
            w_state_nxt = S_IGNORE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Counter restarts on every state change so each state counts from 0.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt     <= 2'd0;
      r_shift   <= 24'd0;
      r_is_read <= 1'b0;
    end else if (cs) begin
      r_cnt <= 2'd0;
    end else if (byte_in_valid) begin
      r_shift <= w_word[23:0];
      if (w_state_nxt != r_state)
        r_cnt <= 2'd0;
      else
        r_cnt <= r_cnt + 2'd1;
      if (r_state == S_CMD)
        r_is_read <= (byte_in == LP_READ);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_addr_vld <= 1'b0;
      r_start    <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_addr_vld <= w_addr_done;
      r_start    <= r_addr_vld & r_is_read;
      if (w_addr_done)
        r_addr <= w_word[APB_ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else if (w_word_done && !r_rx_valid) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= w_word;
    end else if (rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wrap <= 16'd0;
    end else if (w_wrap_done) begin
      r_wrap <= {r_shift[7:0], byte_in};
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_buf <= '0;
      r_occ <= 3'd0;
    end else if (cs) begin
      r_occ <= 3'd0;
    end else if (w_stat_load) begin
      r_buf <= {6'd0, r_err_u, r_err_o, 24'd0};
      r_occ <= 3'd1;
    end else if (w_capture) begin
      r_buf <= tx_data;
      r_occ <= 3'd4;
    end else if (w_pop) begin
      r_buf <= {r_buf[APB_DATA_WIDTH-9:0], 8'd0};
      r_occ <= r_occ - 3'd1;
    end
  end

  // A new error in the status-read cycle survives the clear.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_err_o <= 1'b0;
      r_err_u <= 1'b0;
    end else begin
      if (w_stat_load) begin
        r_err_o <= 1'b0;
        r_err_u <= 1'b0;
      end
      if (w_word_done && r_rx_valid)
        r_err_o <= 1'b1;
      if (w_underrun)
        r_err_u <= 1'b1;
    end
  end

  assign byte_out        = (r_occ != 3'd0) ? r_buf[APB_DATA_WIDTH-1 -: 8]
                                           : UNDERRUN_BYTE;
  assign byte_out_valid  = (r_occ != 3'd0);
  assign rxtx_addr       = r_addr;
  assign rxtx_addr_valid = r_addr_vld;
  assign start_tx        = r_start;
  assign rx_data         = r_rx_data;
  assign rx_valid        = r_rx_valid;
  assign wrap_length     = r_wrap;
  assign err_overrun     = r_err_o;
  assign err_underrun    = r_err_u;

endmodule

// File: tb/tb_spi_slave_cmd_decoder.sv
// Directed bench for spi_slave_cmd_decoder (default parameters).
// Covers both builds of SPI_SLAVE_CMD_STATUS_EN.
module tb_spi_slave_cmd_decoder;

  logic        pclk;
  logic        presetn;
  logic        cs;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready;
  logic [31:0] rxtx_addr;
  logic        rxtx_addr_valid;
  logic        start_tx;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] wrap_length;
  logic        err_overrun;
  logic        err_underrun;

  int n_vec;
  int n_bad;

  spi_slave_cmd_decoder dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .cs              (cs),
    .byte_in         (byte_in),
    .byte_in_valid   (byte_in_valid),
    .byte_out        (byte_out),
    .byte_out_valid  (byte_out_valid),
    .byte_out_ready  (byte_out_ready),
    .rxtx_addr       (rxtx_addr),
    .rxtx_addr_valid (rxtx_addr_valid),
    .start_tx        (start_tx),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .wrap_length     (wrap_length),
    .err_overrun     (err_overrun),
    .err_underrun    (err_underrun)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge pclk);
    byte_in       = b;
    byte_in_valid = 1'b1;
    @(negedge pclk);
    byte_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge pclk);
  endtask

  logic [7:0] rd_exp [4];

  initial begin
    n_vec = 0;
    n_bad = 0;
    rd_exp[0] = 8'h12;
    rd_exp[1] = 8'h34;
    rd_exp[2] = 8'h56;
    rd_exp[3] = 8'h78;
    presetn        = 1'b0;
    cs             = 1'b1;
    byte_in        = 8'h00;
    byte_in_valid  = 1'b0;
    byte_out_ready = 1'b0;
    rx_ready       = 1'b0;
    tx_data        = 32'h0;
    tx_valid       = 1'b0;
    idle(2);
    chk("rst_byte_out", 32'(byte_out), 32'hFF);
    chk("rst_byte_out_valid", 32'(byte_out_valid), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_wrap", 32'(wrap_length), 0);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_errs", 32'({err_overrun, err_underrun}), 0);
    presetn = 1'b1;
    idle(1);

    // SET_WRAP
    cs = 1'b0;
    send(8'h11);
    send(8'h00);
    chk("wrap_mid", 32'(wrap_length), 0);
    send(8'h04);
    chk("wrap_set", 32'(wrap_length), 32'h0004);
    send(8'h22);
    send(8'h33);
    chk("wrap_ignore", 32'(wrap_length), 32'h0004);
    cs = 1'b1;
    idle(2);

    // WRITE with rx_ready held high
    rx_ready = 1'b1;
    cs = 1'b0;
    send(8'h02);
    send(8'h00);
    send(8'h00);
    send(8'h10);
    chk("wr_addr_early", 32'(rxtx_addr_valid), 0);
    send(8'h00);
    chk("wr_addr_valid", 32'(rxtx_addr_valid), 1);
    chk("wr_addr", rxtx_addr, 32'h1000);
    idle(1);
    chk("wr_addr_pulse", 32'(rxtx_addr_valid), 0);
    chk("wr_no_start", 32'(start_tx), 0);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    chk("wr_rx_early", 32'(rx_valid), 0);
    send(8'hEF);
    chk("wr_rx_valid", 32'(rx_valid), 1);
    chk("wr_rx_data", rx_data, 32'hDEADBEEF);
    idle(1);
    chk("wr_rx_clear", 32'(rx_valid), 0);
    chk("wr_no_overrun", 32'(err_overrun), 0);
    cs = 1'b1;
    idle(2);

    // READ with one dummy byte
    rx_ready = 1'b0;
    cs = 1'b0;
    send(8'h0B);
    send(8'h00);
    send(8'h00);
    send(8'h20);
    send(8'h00);
    chk("rd_addr_valid", 32'(rxtx_addr_valid), 1);
    chk("rd_addr", rxtx_addr, 32'h2000);
    chk("rd_start_early", 32'(start_tx), 0);
    chk("rd_tx_ready_dummy", 32'(tx_ready), 0);
    idle(1);
    chk("rd_start", 32'(start_tx), 1);
    chk("rd_addr_pulse", 32'(rxtx_addr_valid), 0);
    send(8'hAA);
    chk("rd_start_pulse", 32'(start_tx), 0);
    chk("rd_tx_ready", 32'(tx_ready), 1);
    chk("rd_empty", 32'(byte_out_valid), 0);
    tx_data  = 32'h12345678;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    chk("rd_full_valid", 32'(byte_out_valid), 1);
    chk("rd_tx_ready_full", 32'(tx_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_byte%0d", i), 32'(byte_out), 32'(rd_exp[i]));
      byte_out_ready = 1'b1;
      @(negedge pclk);
      byte_out_ready = 1'b0;
    end
    chk("rd_drained", 32'(byte_out_valid), 0);
    chk("rd_drained_byte", 32'(byte_out), 32'hFF);
    chk("rd_tx_ready_again", 32'(tx_ready), 1);
    chk("rd_no_underrun", 32'(err_underrun), 0);

    // Underrun with empty buffer
    byte_out_ready = 1'b1;
    @(negedge pclk);
    byte_out_ready = 1'b0;
    chk("ur_flag", 32'(err_underrun), 1);
    chk("ur_byte", 32'(byte_out), 32'hFF);
    cs = 1'b1;
    idle(2);
    chk("ur_sticky", 32'(err_underrun), 1);

    // Overrun: two words with rx_ready low
    cs = 1'b0;
    send(8'h02);
    send(8'h00);
    send(8'h00);
    send(8'h30);
    send(8'h00);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk("ov_first_valid", 32'(rx_valid), 1);
    chk("ov_first_data", rx_data, 32'h11223344);
    send(8'h55);
    send(8'h66);
    send(8'h77);
    send(8'h88);
    chk("ov_flag", 32'(err_overrun), 1);
    chk("ov_data_kept", rx_data, 32'h11223344);
    cs = 1'b1;
    idle(1);
    chk("ov_kept_on_cs", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    @(negedge pclk);
    rx_ready = 1'b0;
    chk("ov_accepted", 32'(rx_valid), 0);
    idle(1);

    // Abort after two address bytes
    cs = 1'b0;
    send(8'h0B);
    send(8'h00);
    send(8'h00);
    cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk($sformatf("ab_no_addr%0d", i), 32'(rxtx_addr_valid), 0);
    end
    cs = 1'b0;
    send(8'h11);
    send(8'h00);
    send(8'h08);
    chk("ab_back_to_cmd", 32'(wrap_length), 32'h0008);
    cs = 1'b1;
    idle(2);

    // Status command
    cs = 1'b0;
    send(8'h05);
`ifdef SPI_SLAVE_CMD_STATUS_EN
    chk("st_byte", 32'(byte_out), 32'h03);
    chk("st_valid", 32'(byte_out_valid), 1);
    chk("st_flags_clr", 32'({err_overrun, err_underrun}), 0);
    chk("st_no_addr", 32'({rxtx_addr_valid, start_tx}), 0);
`else
    chk("st_off_valid", 32'(byte_out_valid), 0);
    chk("st_off_flags", 32'({err_overrun, err_underrun}), 32'h3);
    send(8'h11);
    chk("st_off_ignore", 32'(wrap_length), 32'h0008);
`endif
    cs = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
